// File: rtl/frame_buffer_pkg.sv
// Shared types, default geometry and address helper for the double-buffered LCD frame store.
package frame_buffer_pkg;

  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 144;
  localparam int unsigned FB_PIX_W  = 2;

  typedef logic [FB_PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  // Linear pixel address y*width+x, computed at full 32-bit width.
  function automatic logic [31:0] fb_addr(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] width);
    return (y * width) + x;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One page of the frame store: simple dual-port RAM with a registered read.
module fb_bank
  import frame_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_WIDTH * FB_HEIGHT,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned PIX_W = FB_PIX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Write port; storage itself is never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; only the output register is cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered LCD frame store: PPU writes the back page, scanout reads the front page,
// and a swap request exchanges them between frames.
// Optional feature macro: FRAME_BUFFER_CLEAR_EN (sweep CLEAR_VAL into the new back page after
// every swap and after reset; writes are held off while the sweep runs).
module frame_buffer_dbl
  import frame_buffer_pkg::*;
#(
  parameter int unsigned      WIDTH     = FB_WIDTH,
  parameter int unsigned      HEIGHT    = FB_HEIGHT,
  parameter int unsigned      PIX_W     = FB_PIX_W,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0,
  localparam int unsigned     XW        = $clog2(WIDTH),
  localparam int unsigned     YW        = $clog2(HEIGHT),
  localparam int unsigned     DEPTH     = WIDTH * HEIGHT,
  localparam int unsigned     AW        = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [XW-1:0]    wr_x,
  input  logic [YW-1:0]    wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             front_sel,
  output logic             busy
);

  fb_state_t        state_q, state_d;
  logic             pending_q, pending_d;
  logic             front_d, ack_d, busy_d;

  logic             wr_in, rd_in, wr_fire, rd_fire;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             bank_we;
  logic [AW-1:0]    bank_waddr;
  logic [PIX_W-1:0] bank_wdata;
  logic [PIX_W-1:0] q0, q1;
  logic             rd_sel_q, rd_oob_q;

`ifdef FRAME_BUFFER_CLEAR_EN
  logic             init_q, init_d;
  logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
`endif

  // Range checks and linear addresses for both ports.
  assign wr_in   = (32'(wr_x) < WIDTH) && (32'(wr_y) < HEIGHT);
  assign rd_in   = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign wr_addr = AW'(fb_addr(32'(wr_x), 32'(wr_y), WIDTH));
  assign rd_addr = AW'(fb_addr(32'(rd_x), 32'(rd_y), WIDTH));
  assign wr_fire = wr_en && wr_ready && wr_in;
  assign rd_fire = rd_en && rd_in;

  // Back-page write source: the clear sweep owns the port while it runs.
`ifdef FRAME_BUFFER_CLEAR_EN
  assign bank_we    = wr_fire || (state_q == CLEAR);
  assign bank_waddr = (state_q == CLEAR) ? clr_cnt_q : wr_addr;
  assign bank_wdata = (state_q == CLEAR) ? CLEAR_VAL : wr_data;
`else
  assign bank_we    = wr_fire;
  assign bank_waddr = wr_addr;
  assign bank_wdata = wr_data;
  assign wr_ready   = 1'b1;
`endif

  // Writes go to the back page (~front_sel), reads to the front page.
  fb_bank #(.DEPTH(DEPTH), .AW(AW), .PIX_W(PIX_W)) u_bank0 (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (bank_we && front_sel),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .re      (rd_fire && !front_sel),
    .raddr   (rd_addr),
    .rdata   (q0)
  );

  fb_bank #(.DEPTH(DEPTH), .AW(AW), .PIX_W(PIX_W)) u_bank1 (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (bank_we && !front_sel),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .re      (rd_fire && front_sel),
    .raddr   (rd_addr),
    .rdata   (q1)
  );

  assign rd_data = rd_oob_q ? CLEAR_VAL : (rd_sel_q ? q1 : q0);

  // Next-state logic: swap sequencing, pending merge and clear sweep.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    front_d   = front_sel;
    ack_d     = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    init_d    = init_q;
    clr_cnt_d = clr_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef FRAME_BUFFER_CLEAR_EN
        if (init_q) begin
          state_d   = CLEAR;
          init_d    = 1'b0;
          clr_cnt_d = '0;
          pending_d = pending_q || swap_req;
        end else
`endif
        if (swap_req || pending_q) begin
          state_d   = SWAP;
          front_d   = !front_sel;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end
      end
      SWAP: begin
        pending_d = pending_q || swap_req;
`ifdef FRAME_BUFFER_CLEAR_EN
        state_d   = CLEAR;
        clr_cnt_d = '0;
`else
        state_d   = IDLE;
`endif
      end
`ifdef FRAME_BUFFER_CLEAR_EN
      CLEAR: begin
        pending_d = pending_q || swap_req;
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || pending_d;
  end

  // FSM and status registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      front_sel <= 1'b0;
      swap_ack  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      front_sel <= front_d;
      swap_ack  <= ack_d;
      busy      <= busy_d;
    end
  end

`ifdef FRAME_BUFFER_CLEAR_EN
  // Sweep counter, post-reset clear request and write-ready flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      init_q    <= 1'b1;
      clr_cnt_q <= '0;
      wr_ready  <= 1'b1;
    end else begin
      init_q    <= init_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ready  <= (state_d != CLEAR);
    end
  end
`endif

  // Read pipeline: remember which page and whether the address was in range.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_oob_q <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel_q <= front_sel;
        rd_oob_q <= !rd_in;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed bench for frame_buffer_dbl; honours FRAME_BUFFER_CLEAR_EN (smaller geometry then).
module tb_frame_buffer_dbl;
  import frame_buffer_pkg::*;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam int unsigned TB_W = 40;
  localparam int unsigned TB_H = 36;
`else
  localparam int unsigned TB_W = 160;
  localparam int unsigned TB_H = 144;
`endif
  localparam int unsigned TB_XW    = $clog2(TB_W);
  localparam int unsigned TB_YW    = $clog2(TB_H);
  localparam int unsigned TB_DEPTH = TB_W * TB_H;
  localparam int unsigned OOB_X    = (TB_W > 100) ? 200 : TB_W + 10;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             wr_en, rd_en, swap_req;
  logic [TB_XW-1:0] wr_x, rd_x;
  logic [TB_YW-1:0] wr_y, rd_y;
  pixel_t           wr_data, rd_data;
  logic             wr_ready, rd_valid, swap_ack, front_sel, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_front = 1'b0;

  frame_buffer_dbl #(.WIDTH(TB_W), .HEIGHT(TB_H), .PIX_W(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .front_sel (front_sel),
    .busy      (busy)
  );

  always #5 clock = !clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < int'(TB_DEPTH) + 100) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic write_px(input int x, input int y, input logic [1:0] d);
    wr_en = 1'b1; wr_x = TB_XW'(x); wr_y = TB_YW'(y); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_px(input string tag, input int x, input int y, input logic [1:0] exp);
    rd_en = 1'b1; rd_x = TB_XW'(x); rd_y = TB_YW'(y);
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_swap(input string tag);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_front = !exp_front;
    check({tag, "_ack"}, 32'(swap_ack), 32'd1);
    check({tag, "_front"}, 32'(front_sel), 32'(exp_front));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_ack_off"}, 32'(swap_ack), 32'd0);
    wait_idle();
  endtask

  initial begin
    int n;
    logic [1:0] exp3;
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b1; swap_req = 1'b0;
    wr_x = '0; wr_y = '0; wr_data = '0; rd_x = '0; rd_y = '0;
    tick(); tick();
    rd_en = 1'b0;
    check("rst_front", 32'(front_sel), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ack", 32'(swap_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    wait_idle();

    // Test 1: basic write, swap, read back from new front
    write_px(5, 7, 2'b11);
    do_swap("t1_swap");
    read_px("t1_rd", 5, 7, 2'b11);
    tick();
    check("t1_rd_valid_off", 32'(rd_valid), 32'd0);

    // Test 2: out-of-range writes dropped, out-of-range read returns CLEAR_VAL
    write_px(TB_W - 1, TB_H - 1, 2'b01);
    write_px(0, 0, 2'b10);
    write_px(0, 1, 2'b01);
    write_px(5, 7, 2'b10);
    write_px(OOB_X - TB_W, 11, 2'b10);
    write_px(TB_W, 0, 2'b11);
    write_px(0, TB_H, 2'b11);
    do_swap("t2_swap");
    read_px("t2_corner", TB_W - 1, TB_H - 1, 2'b01);
    read_px("t2_origin", 0, 0, 2'b10);
    read_px("t2_alias", 0, 1, 2'b01);
    read_px("t2_oob", OOB_X, 10, 2'b00);

    // Test 3: read and write in the swap cycle see old front / old back
    swap_req = 1'b1;
    rd_en = 1'b1; rd_x = TB_XW'(5); rd_y = TB_YW'(7);
    wr_en = 1'b1; wr_x = TB_XW'(6); wr_y = TB_YW'(7); wr_data = 2'b01;
    tick();
    swap_req = 1'b0; wr_en = 1'b0;
    exp_front = !exp_front;
    check("t3_old_front", 32'(rd_data), 32'd2);
    check("t3_ack", 32'(swap_ack), 32'd1);
    check("t3_front", 32'(front_sel), 32'(exp_front));
    tick();
    rd_en = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    exp3 = 2'b00;
`else
    exp3 = 2'b11;
`endif
    check("t3_new_front", 32'(rd_data), 32'(exp3));
    read_px("t3_swap_cycle_wr", 6, 7, 2'b01);
    wait_idle();

    // Test 4: back-to-back swap requests, second one pended
    swap_req = 1'b1;
    tick();
    exp_front = !exp_front;
    check("t4_first_front", 32'(front_sel), 32'(exp_front));
    tick();
    swap_req = 1'b0;
    check("t4_pend_front", 32'(front_sel), 32'(exp_front));
    check("t4_pend_ack", 32'(swap_ack), 32'd0);
    check("t4_pend_busy", 32'(busy), 32'd1);
    n = 0;
    while (front_sel == exp_front && n < int'(TB_DEPTH) + 50) begin
      tick();
      n++;
    end
    exp_front = !exp_front;
`ifdef FRAME_BUFFER_CLEAR_EN
    check("t4_second_delay", 32'(n), 32'(TB_DEPTH + 1));
`else
    check("t4_second_delay", 32'(n), 32'd1);
`endif
    check("t4_second_front", 32'(front_sel), 32'(exp_front));
    check("t4_second_ack", 32'(swap_ack), 32'd1);
    tick();
    wait_idle();
    check("t4_idle_busy", 32'(busy), 32'd0);

`ifdef FRAME_BUFFER_CLEAR_EN
    // Test 5: writes during clear are refused; cleared page reads zero
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_front = !exp_front;
    tick();
    check("t5_ready_low", 32'(wr_ready), 32'd0);
    repeat (100) tick();
    check("t5_ready_low2", 32'(wr_ready), 32'd0);
    write_px(0, 0, 2'b11);
    wait_idle();
    check("t5_busy_done", 32'(busy), 32'd0);
    check("t5_ready_back", 32'(wr_ready), 32'd1);
    do_swap("t5_swap");
    read_px("t5_origin", 0, 0, 2'b00);
    read_px("t5_corner", TB_W - 1, TB_H - 1, 2'b00);
    read_px("t5_mid", 6, 7, 2'b00);
`else
    check("t5_ready_idle", 32'(wr_ready), 32'd1);
`endif

    // Test 6: reset during swap/clear with a swap pending
    if (exp_front) do_swap("t6_pre");
    swap_req = 1'b1;
    tick();
    tick();
    swap_req = 1'b0;
    exp_front = !exp_front;
`ifdef FRAME_BUFFER_CLEAR_EN
    repeat (98) tick();
`endif
    check("t6_pre_front", 32'(front_sel), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rd_en = 1'b1; rd_x = '0; rd_y = '0;
    reset_n = 1'b0;
    tick();
    rd_en = 1'b0;
    check("t6_rst_front", 32'(front_sel), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ack", 32'(swap_ack), 32'd0);
    check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    exp_front = 1'b0;
    tick();
`ifdef FRAME_BUFFER_CLEAR_EN
    check("t6_init_clear_busy", 32'(busy), 32'd1);
    check("t6_init_clear_ready", 32'(wr_ready), 32'd0);
    wait_idle();
`endif
    repeat (3) tick();
    check("t6_no_pending_front", 32'(front_sel), 32'd0);
    check("t6_no_pending_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
